// File: rtl/seq_detect_ctrl_pkg.sv
// Shared definitions for the serial pattern-detection controller:
// FSM state encoding and the configuration loaded at reset.
package seqdet_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Reset configuration: 4-bit pattern 1011, overlapping, run until abort.
    localparam logic [15:0] DEF_PATTERN = 16'b1011;
    localparam int          DEF_LEN     = 4;
    localparam logic        DEF_OVERLAP = 1'b1;
    localparam int          DEF_TARGET  = 0;

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Configuration port of the detector: valid/ready handshake plus the
// pattern, length, overlap mode and match target it carries.
interface seq_detect_ctrl_if #(
    parameter int PW = 8,
    parameter int CW = 8,
    parameter int LW = $clog2(PW + 1)
);
    logic          valid;
    logic          ready;
    logic [PW-1:0] pattern;
    logic [LW-1:0] len;
    logic          overlap;
    logic [CW-1:0] target;

    modport master (output valid, pattern, len, overlap, target, input ready);
    modport slave  (input valid, pattern, len, overlap, target, output ready);
endinterface

// File: rtl/seq_detect_ctrl_pattern_cmp.sv
// Bit history, fill counter and length-masked comparator. hit reports a
// detection for the bit being shifted in on this edge.
module pattern_cmp #(
    parameter int PW = 8,
    parameter int LW = $clog2(PW + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          shift,
    input  logic          sbit,
    input  logic          overlap,
    input  logic [LW-1:0] len,
    input  logic [PW-1:0] pattern,
    output logic          hit
);
    logic [PW-1:0] hist, hist_next, mask;
    logic [LW-1:0] fill, fill_next;

    always_comb begin
        hist_next = {hist[PW-2:0], sbit};
        fill_next = (fill >= len) ? len : fill + LW'(1);
        for (int i = 0; i < PW; i++) mask[i] = (i < int'(len));
        hit = shift && ((hist_next & mask) == (pattern & mask)) && (fill_next >= len);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
            fill <= '0;
        end else if (clear) begin
            hist <= '0;
            fill <= '0;
        end else if (shift) begin
            hist <= hist_next;
            // Non-overlapping mode demands len fresh bits after each match.
            fill <= (hit && !overlap) ? '0 : fill_next;
        end
    end
endmodule

// File: rtl/seq_detect_ctrl.sv
// Reconfigurable serial pattern detector: config registers, session FSM,
// saturating match counter and registered match/done pulses.
module seq_detect_ctrl
    import seqdet_pkg::*;
#(
    parameter int PW = 8,
    parameter int CW = 8,
    parameter int LW = $clog2(PW + 1)
) (
    input  logic            clk,
    input  logic            rst,
    seq_detect_ctrl_if.slave cfg,
    input  logic            start,
    input  logic            abort,
    input  logic            din,
    input  logic            din_valid,
    output logic            match,
    output logic [CW-1:0]   match_count,
    output logic            busy,
    output logic            done
);
    state_t        state;
    logic [PW-1:0] pat_q;
    logic [LW-1:0] len_q, len_in;
    logic          ovl_q;
    logic [CW-1:0] tgt_q, cnt_next;
    logic          hit, shift, clear;

    assign cfg.ready = (state == IDLE);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign clear     = (state == IDLE) && start;
    // Abort wins over a same-edge sample, so that bit never reaches the history.
    assign shift     = (state == RUN) && din_valid && !abort;
    assign cnt_next  = (match_count == {CW{1'b1}}) ? match_count : match_count + CW'(1);

    always_comb begin
        len_in = cfg.len;
        if (cfg.len == '0)            len_in = LW'(1);
        else if (cfg.len > LW'(PW))   len_in = LW'(PW);
    end

    pattern_cmp #(.PW(PW), .LW(LW)) u_cmp (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .shift   (shift),
        .sbit    (din),
        .overlap (ovl_q),
        .len     (len_q),
        .pattern (pat_q),
        .hit     (hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            match       <= 1'b0;
            match_count <= '0;
            pat_q       <= DEF_PATTERN[PW-1:0];
            len_q       <= LW'(DEF_LEN);
            ovl_q       <= DEF_OVERLAP;
            tgt_q       <= CW'(DEF_TARGET);
        end else begin
            match <= 1'b0;
            if (cfg.valid && state == IDLE) begin
                pat_q <= cfg.pattern;
                len_q <= len_in;
                ovl_q <= cfg.overlap;
                tgt_q <= cfg.target;
            end
            unique case (state)
                IDLE: if (start) begin
                    state       <= RUN;
                    match_count <= '0;
                end
                RUN: if (abort) begin
                    state <= IDLE;
                end else if (hit) begin
                    match       <= 1'b1;
                    match_count <= cnt_next;
                    if (tgt_q != '0 && cnt_next == tgt_q) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: a bit-queue model predicts every
// output each cycle, with literal spot checks pinning the model.
module tb_seq_detect_ctrl;
    localparam int PW = 8;
    localparam int CW = 8;
    localparam int LW = $clog2(PW + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start, abort, din, din_valid;
    logic          match, busy, done;
    logic [CW-1:0] match_count;
    int            n_chk = 0;
    int            n_pass = 0;

    seq_detect_ctrl_if #(.PW(PW), .CW(CW)) cfg();

    seq_detect_ctrl #(.PW(PW), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg         (cfg.slave),
        .start       (start),
        .abort       (abort),
        .din         (din),
        .din_valid   (din_valid),
        .match       (match),
        .match_count (match_count),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Model: session flags, every sampled bit of the session, bits since
    // session start / last match, and the active configuration.
    bit            m_run, m_done, m_match;
    int            m_cnt, m_since, m_len, m_tgt;
    bit            m_ovl;
    bit            m_bits[$];
    logic [PW-1:0] m_pat;

    bit s7[7] = '{1, 0, 1, 1, 0, 1, 1};
    bit s5[5] = '{1, 1, 0, 1, 1};

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        m_run = 0; m_done = 0; m_match = 0; m_cnt = 0; m_since = 0;
        m_pat = PW'(11); m_len = 4; m_ovl = 1; m_tgt = 0;
        m_bits.delete();
    endtask

    task automatic model_step();
        bit idle;
        bit tail_ok;
        idle = !m_run && !m_done;
        m_match = 0;
        if (idle && cfg.valid) begin
            m_pat = cfg.pattern;
            m_len = (int'(cfg.len) == 0) ? 1 : ((int'(cfg.len) > PW) ? PW : int'(cfg.len));
            m_ovl = cfg.overlap;
            m_tgt = int'(cfg.target);
        end
        if (m_done) m_done = 0;
        else if (idle) begin
            if (start) begin
                m_run = 1; m_bits.delete(); m_since = 0; m_cnt = 0;
            end
        end else if (abort) m_run = 0;
        else if (din_valid) begin
            m_bits.push_back(din);
            m_since++;
            tail_ok = (m_since >= m_len);
            for (int i = 0; i < m_len && tail_ok; i++)
                if (m_bits[m_bits.size() - 1 - i] != m_pat[i]) tail_ok = 0;
            if (tail_ok) begin
                m_match = 1;
                if (m_cnt < 2**CW - 1) m_cnt++;
                if (!m_ovl) m_since = 0;
                if (m_tgt != 0 && m_cnt == m_tgt) begin
                    m_run = 0; m_done = 1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        chk("cfg_ready",   int'(cfg.ready),   int'(!m_run && !m_done));
        chk("busy",        int'(busy),        int'(m_run));
        chk("done",        int'(done),        int'(m_done));
        chk("match",       int'(match),       int'(m_match));
        chk("match_count", int'(match_count), m_cnt);
    end

    // One clock of stimulus; every edge after reset goes through here.
    task automatic cyc(input bit dv, input bit d, input bit st, input bit ab, input bit cv);
        @(negedge clk);
        #1;
        din_valid = dv; din = d; start = st; abort = ab; cfg.valid = cv;
        model_step();
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int pat, input int len, input bit ovl, input int tgt);
        cfg.pattern = PW'(pat); cfg.len = LW'(len); cfg.overlap = ovl; cfg.target = CW'(tgt);
    endtask

    initial begin
        rst = 1'b1;
        start = 0; abort = 0; din = 0; din_valid = 0; cfg.valid = 0;
        set_cfg(11, 4, 1, 0);
        model_reset();
        #1;
        chk("rst_ready", int'(cfg.ready), 1);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_count", int'(match_count), 0);
        @(negedge clk); #1;
        rst = 1'b0;
        model_step();

        // Overlap, default config: 1011011 hits at bits 4 and 7.
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 7; i++) begin
            cyc(1, s7[i], 0, 0, 0);
            if (i == 3 || i == 6) begin after_edge(); chk("ovl_match", int'(match), 1); end
        end
        cyc(0, 0, 0, 0, 0);
        after_edge(); chk("ovl_count", int'(match_count), 2);
        cyc(0, 0, 0, 1, 0);
        after_edge(); chk("ovl_retain", int'(match_count), 2);

        // Non-overlap, captured on the same edge as start: single hit.
        set_cfg(11, 4, 0, 0);
        cyc(0, 0, 1, 0, 1);
        for (int i = 0; i < 7; i++) begin
            cyc(1, s7[i], 0, 0, 0);
            if (i == 6) begin after_edge(); chk("novl_no_match7", int'(match), 0); end
        end
        cyc(0, 0, 0, 0, 0);
        after_edge(); chk("novl_count", int'(match_count), 1);
        cyc(0, 0, 0, 1, 0);

        // Target 3, pattern 11 on a run of ones: done with third match.
        set_cfg(3, 2, 1, 3);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 0, 0, 0);
            if (i == 3) begin
                after_edge();
                chk("tgt_done", int'(done), 1);
                chk("tgt_match", int'(match), 1);
            end
        end
        cyc(1, 1, 0, 0, 0);
        after_edge(); chk("tgt_busy_low", int'(busy), 0);
        cyc(1, 1, 1, 0, 0);
        after_edge(); chk("tgt_restart", int'(busy), 1);
        cyc(0, 0, 0, 1, 0);

        // Abort on the completing bit.
        set_cfg(11, 4, 1, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 1, 0);
        after_edge();
        chk("abort_match", int'(match), 0);
        chk("abort_count", int'(match_count), 0);
        chk("abort_done",  int'(done), 0);

        // Config offered mid-session is ignored; din_valid gaps are holds.
        cyc(0, 0, 1, 0, 0);
        set_cfg(3, 2, 1, 0);
        cyc(0, 0, 0, 0, 1);
        after_edge(); chk("run_ready", int'(cfg.ready), 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, s5[i], 0, 0, 0);
            if (i == 1) begin after_edge(); chk("gap_no_newcfg", int'(match), 0); end
            cyc(0, 0, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 0);
        after_edge(); chk("gap_count", int'(match_count), 1);
        cyc(0, 0, 0, 1, 0);

        // Length 0 acts as length 1 on pattern bit 0.
        set_cfg(1, 0, 1, 0);
        cyc(0, 0, 1, 0, 1);
        cyc(1, 0, 0, 0, 0);
        after_edge(); chk("len0_zero", int'(match), 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        after_edge(); chk("len0_count", int'(match_count), 2);

        // Asynchronous reset mid-session, then the default config is back.
        cyc(1, 1, 0, 0, 0);
        @(negedge clk); #1;
        rst = 1'b1;
        din_valid = 0; start = 0; abort = 0; cfg.valid = 0;
        model_reset();
        #1;
        chk("mid_rst_busy",  int'(busy), 0);
        chk("mid_rst_count", int'(match_count), 0);
        chk("mid_rst_ready", int'(cfg.ready), 1);
        chk("mid_rst_match", int'(match), 0);
        @(negedge clk); #1;
        rst = 1'b0;
        model_step();
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, s7[i], 0, 0, 0);
        after_edge(); chk("post_rst_match", int'(match), 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
